// File: rtl/change_dispenser_if.sv
// Request, hopper and status signals between the vending controller and the change dispenser.
// The master modport is the controller/hopper side; the slave modport is the dispenser.
interface change_dispenser_if #(
    parameter int AMOUNT_W = 8,
    parameter int CNT_W    = 6
);
    logic                changeValid;
    logic [AMOUNT_W-1:0] changeAmount;
    logic                changeReady;
    logic                hopperBusy;
    logic                refill;
    logic                fiveKurusOut;
    logic                tenKurusOut;
    logic                twentyFiveKurusOut;
    logic                done;
    logic                shortfall;
    logic [AMOUNT_W-1:0] remaining;
    logic [CNT_W-1:0]    count25;
    logic [CNT_W-1:0]    count10;
    logic [CNT_W-1:0]    count5;

    modport master (
        output changeValid, changeAmount, hopperBusy, refill,
        input  changeReady, fiveKurusOut, tenKurusOut, twentyFiveKurusOut,
        input  done, shortfall, remaining, count25, count10, count5
    );

    modport slave (
        input  changeValid, changeAmount, hopperBusy, refill,
        output changeReady, fiveKurusOut, tenKurusOut, twentyFiveKurusOut,
        output done, shortfall, remaining, count25, count10, count5
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays a change amount by pulsing the coin hopper, choosing coins greedily (25, 10, 5)
// from a tracked inventory; reports completion, any unpaid remainder and inventory counts.
module change_dispenser #(
    parameter int AMOUNT_W = 8,
    parameter int CNT_W    = 6,
    parameter int INIT_25  = 4,
    parameter int INIT_10  = 4,
    parameter int INIT_5   = 4
) (
    input  logic clock,
    input  logic reset,
    change_dispenser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [AMOUNT_W-1:0] remaining_reg;
    logic [CNT_W-1:0]    count25_reg;
    logic [CNT_W-1:0]    count10_reg;
    logic [CNT_W-1:0]    count5_reg;
    logic                pulse25_reg;
    logic                pulse10_reg;
    logic                pulse5_reg;
    logic                shortfall_reg;

    logic accept;
    logic active;
    logic take25;
    logic take10;
    logic take5;
    logic settle;
    logic ready;
    logic done_out;

    // One greedy decision per non-busy DISPENSE edge; settle means no coin fits any more.
    always_comb begin
        accept = (state_reg == IDLE) && !bus.refill && bus.changeValid;
        active = (state_reg == DISPENSE) && !bus.hopperBusy;
        take25 = active && (remaining_reg >= AMOUNT_W'(25)) && (count25_reg != '0);
        take10 = active && !take25 && (remaining_reg >= AMOUNT_W'(10)) && (count10_reg != '0);
        take5  = active && !take25 && !take10 && (remaining_reg >= AMOUNT_W'(5))
                 && (count5_reg != '0);
        settle = active && !take25 && !take10 && !take5;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (accept) state_next = DISPENSE;
            DISPENSE: if (settle) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        done_out = 1'b0;
        case (state_reg)
            IDLE:    ready    = !bus.refill;
            DONE:    done_out = 1'b1;
            default: ;
        endcase
    end

    // Pulses are registered so each coin appears exactly one cycle after its decision edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_reg <= '0;
            shortfall_reg <= 1'b0;
            pulse25_reg   <= 1'b0;
            pulse10_reg   <= 1'b0;
            pulse5_reg    <= 1'b0;
            count25_reg   <= CNT_W'(INIT_25);
            count10_reg   <= CNT_W'(INIT_10);
            count5_reg    <= CNT_W'(INIT_5);
        end else begin
            pulse25_reg <= take25;
            pulse10_reg <= take10;
            pulse5_reg  <= take5;
            if ((state_reg == IDLE) && bus.refill) begin
                count25_reg <= CNT_W'(INIT_25);
                count10_reg <= CNT_W'(INIT_10);
                count5_reg  <= CNT_W'(INIT_5);
            end
            if (accept) begin
                remaining_reg <= bus.changeAmount;
                shortfall_reg <= 1'b0;
            end
            if (take25) begin
                remaining_reg <= remaining_reg - AMOUNT_W'(25);
                count25_reg   <= count25_reg - CNT_W'(1);
            end
            if (take10) begin
                remaining_reg <= remaining_reg - AMOUNT_W'(10);
                count10_reg   <= count10_reg - CNT_W'(1);
            end
            if (take5) begin
                remaining_reg <= remaining_reg - AMOUNT_W'(5);
                count5_reg    <= count5_reg - CNT_W'(1);
            end
            if (settle) begin
                shortfall_reg <= (remaining_reg != '0);
            end
        end
    end

    assign bus.changeReady        = ready;
    assign bus.done               = done_out;
    assign bus.twentyFiveKurusOut = pulse25_reg;
    assign bus.tenKurusOut        = pulse10_reg;
    assign bus.fiveKurusOut       = pulse5_reg;
    assign bus.shortfall          = shortfall_reg;
    assign bus.remaining          = remaining_reg;
    assign bus.count25            = count25_reg;
    assign bus.count10            = count10_reg;
    assign bus.count5             = count5_reg;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized requests checked against a greedy-payout model with an inventory
// tally; also covers refill blocking, zero amounts and an asynchronous reset mid-request.
module tb_change_dispenser;
    localparam int AW = 8;
    localparam int CW = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    change_dispenser_if #(.AMOUNT_W(AW), .CNT_W(CW)) dif ();

    change_dispenser #(
        .AMOUNT_W(AW), .CNT_W(CW), .INIT_25(4), .INIT_10(4), .INIT_5(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (dif.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m25 = 4;
    int m10 = 4;
    int m5  = 4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_c25"}, 32'(dif.count25), m25);
        chk({tag, "_c10"}, 32'(dif.count10), m10);
        chk({tag, "_c5"},  32'(dif.count5),  m5);
    endtask

    // mode 0: hopper never busy; 1: busy on the first two dispense edges; 2: random busy
    task automatic run_request(input int amt, input int mode);
        int  exp_seq[$];
        int  got_seq[$];
        int  rem;
        int  edges;
        int  busy_edges;
        bit  busy_now;
        bit  fin;
        logic [2:0] p;
        logic [AW-1:0] amt_v;

        rem = amt;
        forever begin
            if (rem >= 25 && m25 > 0) begin exp_seq.push_back(25); rem -= 25; m25--; end
            else if (rem >= 10 && m10 > 0) begin exp_seq.push_back(10); rem -= 10; m10--; end
            else if (rem >= 5 && m5 > 0) begin exp_seq.push_back(5); rem -= 5; m5--; end
            else break;
        end

        chk("ready_pre", 32'(dif.changeReady), 1);
        amt_v = AW'(amt);
        dif.changeValid  = 1'b1;
        dif.changeAmount = amt_v;
        tick();
        dif.changeValid = 1'b0;
        chk("ready_accepted", 32'(dif.changeReady), 0);

        edges = 0;
        busy_edges = 0;
        fin = 1'b0;
        while (!fin && edges < 600) begin
            busy_now = (mode == 1) ? (edges < 2) :
                       (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            dif.hopperBusy = busy_now;
            tick();
            edges++;
            if (busy_now) busy_edges++;
            p = {dif.twentyFiveKurusOut, dif.tenKurusOut, dif.fiveKurusOut};
            chk("onehot", 32'($countones(p) <= 1), 1);
            if (busy_now) chk("busy_quiet", 32'(p), 0);
            if (p[2]) got_seq.push_back(25);
            if (p[1]) got_seq.push_back(10);
            if (p[0]) got_seq.push_back(5);
            if (dif.done) fin = 1'b1;
        end
        dif.hopperBusy = 1'b0;

        chk("done_seen", 32'(fin), 1);
        chk("n_coins", got_seq.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size(); i++)
            chk("coin", (i < got_seq.size()) ? got_seq[i] : -1, exp_seq[i]);
        chk("latency", edges, exp_seq.size() + 1 + busy_edges);
        chk("shortfall", 32'(dif.shortfall), 32'(rem != 0));
        chk("remaining", 32'(dif.remaining), rem);
        chk_counts("req");

        tick();
        chk("done_one_cycle", 32'(dif.done), 0);
        chk("ready_post", 32'(dif.changeReady), 1);
        chk("shortfall_held", 32'(dif.shortfall), 32'(rem != 0));
        chk("remaining_held", 32'(dif.remaining), rem);
        $display("req amt=%0d mode=%0d coins=%0d busy=%0d unpaid=%0d inv=%0d/%0d/%0d",
                 amt, mode, got_seq.size(), busy_edges, rem, m25, m10, m5);
    endtask

    task automatic do_refill(input bit with_valid);
        dif.refill       = 1'b1;
        dif.changeValid  = with_valid;
        dif.changeAmount = AW'(50);
        #1;
        chk("ready_refill", 32'(dif.changeReady), 0);
        tick();
        dif.refill      = 1'b0;
        dif.changeValid = 1'b0;
        m25 = 4; m10 = 4; m5 = 4;
        chk_counts("refill");
        tick();
        chk("refill_no_accept", 32'(dif.changeReady), 1);
        chk("refill_no_done", 32'(dif.done), 0);
        $display("refill valid=%0d inv=%0d/%0d/%0d", with_valid, m25, m10, m5);
    endtask

    task automatic reset_mid_request();
        int seen;
        int guard;
        chk("ready_pre_rst", 32'(dif.changeReady), 1);
        dif.changeValid  = 1'b1;
        dif.changeAmount = AW'(200);
        tick();
        dif.changeValid = 1'b0;
        seen = 0;
        guard = 0;
        while (seen < 2 && guard < 20) begin
            tick();
            guard++;
            if (dif.twentyFiveKurusOut || dif.tenKurusOut || dif.fiveKurusOut) seen++;
        end
        chk("rst_two_pulses", seen, 2);
        reset = 1'b0;
        #1;
        chk("rst_pulses_drop",
            32'({dif.twentyFiveKurusOut, dif.tenKurusOut, dif.fiveKurusOut}), 0);
        m25 = 4; m10 = 4; m5 = 4;
        chk_counts("rst");
        chk("rst_remaining", 32'(dif.remaining), 0);
        chk("rst_shortfall", 32'(dif.shortfall), 0);
        chk("rst_done", 32'(dif.done), 0);
        tick();
        tick();
        reset = 1'b1;
        chk("rst_ready", 32'(dif.changeReady), 1);
        tick();
        chk("rst_quiet",
            32'({dif.twentyFiveKurusOut, dif.tenKurusOut, dif.fiveKurusOut, dif.done}), 0);
        chk("rst_ready_after", 32'(dif.changeReady), 1);
        $display("reset mid-request inv=%0d/%0d/%0d", m25, m10, m5);
    endtask

    initial begin
        int amt;
        dif.changeValid  = 1'b0;
        dif.changeAmount = '0;
        dif.hopperBusy   = 1'b0;
        dif.refill       = 1'b0;
        reset            = 1'b0;
        repeat (2) tick();
        chk("reset_pulses",
            32'({dif.twentyFiveKurusOut, dif.tenKurusOut, dif.fiveKurusOut}), 0);
        chk("reset_done", 32'(dif.done), 0);
        chk("reset_shortfall", 32'(dif.shortfall), 0);
        chk("reset_remaining", 32'(dif.remaining), 0);
        chk_counts("reset");
        reset = 1'b1;
        tick();
        chk("reset_ready", 32'(dif.changeReady), 1);

        run_request(40, 0);
        do_refill(1'b0);
        run_request(30, 1);
        do_refill(1'b0);
        run_request(200, 0);
        do_refill(1'b1);
        run_request(7, 0);
        run_request(0, 0);
        do_refill(1'b0);
        reset_mid_request();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) do_refill($urandom_range(0, 1) == 1);
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 60));
            run_request(amt, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
